// File: rtl/multi_timer.sv
// N-channel timer/counter peripheral with one-shot, auto-reload and square-wave modes,
// sticky write-1-to-clear pending flags and an aggregated masked interrupt.
module multi_timer #(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PrAddr,
  input  logic              WE,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              InterruptRequest,
  output logic [N_CH-1:0]   ChIrq,
  output logic [N_CH-1:0]   WaveOut
);

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_SQUARE  = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(4 * N_CH);

  logic [N_CH-1:0]  en_q, en_d, im_q, im_d, pend_q, pend_d, wave_q, wave_d;
  mode_e            mode_q [N_CH];
  mode_e            mode_d [N_CH];
  logic [CNT_W-1:0] preset_q [N_CH];
  logic [CNT_W-1:0] preset_d [N_CH];
  logic [CNT_W-1:0] count_q [N_CH];
  logic [CNT_W-1:0] count_d [N_CH];

  logic [N_CH-1:0]  ctrl_wr, preset_wr, running, fire, status_clr;

  always_comb begin
    ctrl_wr    = '0;
    preset_wr  = '0;
    running    = '0;
    fire       = '0;
    status_clr = (WE && PrAddr == STATUS_ADDR) ? DataIn[N_CH-1:0] : '0;
    for (int c = 0; c < N_CH; c++) begin
      ctrl_wr[c]   = WE && (PrAddr == ADDR_W'(4 * c));
      preset_wr[c] = WE && (PrAddr == ADDR_W'(4 * c + 1));
      running[c]   = en_q[c] && (mode_q[c] != MODE_HOLD);
      fire[c]      = running[c] && (count_q[c] == '0);
    end
  end

  // Counting and event handling first; a CTRL write then overrides the
  // control fields, and an EN 0->1 arm overrides COUNT with PRESET.
  always_comb begin
    en_d   = en_q;
    im_d   = im_q;
    pend_d = pend_q;
    wave_d = wave_q;
    for (int c = 0; c < N_CH; c++) begin
      mode_d[c]   = mode_q[c];
      count_d[c]  = count_q[c];
      preset_d[c] = preset_wr[c] ? DataIn[CNT_W-1:0] : preset_q[c];
      if (running[c]) begin
        if (!fire[c]) begin
          count_d[c] = count_q[c] - CNT_W'(1);
        end else begin
          case (mode_q[c])
            MODE_ONESHOT: en_d[c] = 1'b0;
            MODE_RELOAD:  count_d[c] = preset_q[c];
            MODE_SQUARE: begin
              count_d[c] = preset_q[c];
              wave_d[c]  = ~wave_q[c];
            end
            default: ;
          endcase
        end
      end
      pend_d[c] = (pend_q[c] & ~status_clr[c]) | fire[c];
      if (ctrl_wr[c]) begin
        en_d[c]   = DataIn[0];
        mode_d[c] = mode_e'(DataIn[2:1]);
        im_d[c]   = DataIn[3];
        if (DataIn[0] && !en_q[c]) count_d[c] = preset_q[c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      im_q   <= '0;
      pend_q <= '0;
      wave_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        mode_q[c]   <= MODE_ONESHOT;
        preset_q[c] <= '0;
        count_q[c]  <= '0;
      end
    end else begin
      en_q   <= en_d;
      im_q   <= im_d;
      pend_q <= pend_d;
      wave_q <= wave_d;
      for (int c = 0; c < N_CH; c++) begin
        mode_q[c]   <= mode_d[c];
        preset_q[c] <= preset_d[c];
        count_q[c]  <= count_d[c];
      end
    end
  end

  always_comb begin
    DataOut = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (PrAddr[ADDR_W-1:2] == (ADDR_W-2)'(c)) begin
        case (PrAddr[1:0])
          2'd0:    DataOut = {28'b0, im_q[c], mode_q[c], en_q[c]};
          2'd1:    DataOut = 32'(preset_q[c]);
          2'd2:    DataOut = 32'(count_q[c]);
          default: ;
        endcase
      end
    end
    if (PrAddr == STATUS_ADDR) DataOut = 32'(pend_q);
  end

  assign ChIrq            = pend_q & im_q;
  assign InterruptRequest = |ChIrq;
  assign WaveOut          = wave_q;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus random bus traffic,
// all compared against a behavioural register-map model of the timer channels.
module tb_multi_timer;
  localparam int N_CH        = 2;
  localparam int CNT_W       = 8;
  localparam int ADDR_W      = 4;
  localparam int STATUS_ADDR = 4 * N_CH;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] PrAddr;
  logic              WE;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              InterruptRequest;
  logic [N_CH-1:0]   ChIrq;
  logic [N_CH-1:0]   WaveOut;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model state, one entry per channel.
  bit mEn[N_CH];
  int mMode[N_CH];
  bit mIm[N_CH];
  int mPreset[N_CH];
  int mCount[N_CH];
  bit mPend[N_CH];
  bit mWave[N_CH];

  multi_timer #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .PrAddr(PrAddr),
    .WE(WE),
    .DataIn(DataIn),
    .DataOut(DataOut),
    .InterruptRequest(InterruptRequest),
    .ChIrq(ChIrq),
    .WaveOut(WaveOut)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input int addr);
    int c;
    logic [31:0] r;
    r = 32'h0;
    if (addr < 4 * N_CH) begin
      c = addr / 4;
      case (addr % 4)
        0: r = (mIm[c] ? 32'd8 : 32'd0) + 32'(mMode[c] * 2) + (mEn[c] ? 32'd1 : 32'd0);
        1: r = 32'(mPreset[c]);
        2: r = 32'(mCount[c]);
        default: r = 32'h0;
      endcase
    end else if (addr == STATUS_ADDR) begin
      for (int k = 0; k < N_CH; k++) if (mPend[k]) r = r + (32'd1 << k);
    end
    return r;
  endfunction

  function automatic logic [N_CH-1:0] modelIrq();
    logic [N_CH-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k] = mPend[k] && mIm[k];
    return r;
  endfunction

  function automatic logic [N_CH-1:0] modelWave();
    logic [N_CH-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k] = mWave[k];
    return r;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < N_CH; k++) begin
      mEn[k] = 0; mMode[k] = 0; mIm[k] = 0; mPreset[k] = 0;
      mCount[k] = 0; mPend[k] = 0; mWave[k] = 0;
    end
  endtask

  // One clock edge of the register map, channel by channel from the old state.
  task automatic modelStep(input int addr, input bit we, input logic [31:0] data);
    for (int k = 0; k < N_CH; k++) begin
      bit ctrlWrite, fire, nEn, nIm, nPend, nWave;
      int nMode, nCount, nPreset;
      ctrlWrite = we && (addr == 4 * k);
      fire      = mEn[k] && mMode[k] != 3 && mCount[k] == 0;
      nEn = mEn[k]; nIm = mIm[k]; nMode = mMode[k]; nCount = mCount[k];
      nPreset = mPreset[k]; nPend = mPend[k]; nWave = mWave[k];
      if (mEn[k] && mMode[k] != 3) begin
        if (mCount[k] > 0) nCount = mCount[k] - 1;
        else if (mMode[k] == 0) nEn = 0;
        else begin
          nCount = mPreset[k];
          if (mMode[k] == 2) nWave = !mWave[k];
        end
      end
      if (we && addr == STATUS_ADDR && data[k]) nPend = 0;
      if (fire) nPend = 1;
      if (ctrlWrite) begin
        nEn   = data[0];
        nMode = int'(data[2:1]);
        nIm   = data[3];
        if (data[0] && !mEn[k]) nCount = mPreset[k];
      end
      if (we && addr == 4 * k + 1) nPreset = int'(data) % (1 << CNT_W);
      mEn[k] = nEn; mIm[k] = nIm; mMode[k] = nMode; mCount[k] = nCount;
      mPreset[k] = nPreset; mPend[k] = nPend; mWave[k] = nWave;
    end
  endtask

  task automatic applyStimulus(input int addr, input bit we, input logic [31:0] data);
    @(negedge clk);
    PrAddr = ADDR_W'(addr);
    WE     = we;
    DataIn = data;
    #1;
    checkOutput($sformatf("read@%0d", addr), DataOut, modelRead(addr));
    checkOutput("irq", 32'(InterruptRequest), 32'(|modelIrq()));
    checkOutput("chirq", 32'(ChIrq), 32'(modelIrq()));
    checkOutput("wave", 32'(WaveOut), 32'(modelWave()));
    @(posedge clk);
    modelStep(addr, we, data);
  endtask

  task automatic idle(input int cycles, input int addr);
    for (int i = 0; i < cycles; i++) applyStimulus(addr, 1'b0, 32'h0);
  endtask

  initial begin
    int guard;
    int addr;
    bit we;
    logic [31:0] data;

    reset  = 1'b1;
    PrAddr = '0;
    WE     = 1'b0;
    DataIn = '0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_dataout", DataOut, 32'h0);
    checkOutput("reset_irq", 32'(InterruptRequest), 32'h0);
    checkOutput("reset_wave", 32'(WaveOut), 32'h0);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) applyStimulus(a, 1'b0, 32'h0);

    // Ch0 one-shot, PRESET=5.
    applyStimulus(1, 1'b1, 32'd5);
    applyStimulus(0, 1'b1, 32'h9);
    idle(9, 2);
    checkOutput("oneshot_pend", 32'(ChIrq[0]), 32'h1);
    applyStimulus(0, 1'b0, 32'h0);

    // Ch1 auto-reload, PRESET=3, then W1C and a W1C/event collision.
    applyStimulus(5, 1'b1, 32'd3);
    applyStimulus(4, 1'b1, 32'hB);
    idle(10, STATUS_ADDR);
    applyStimulus(STATUS_ADDR, 1'b1, 32'h3);
    guard = 0;
    while (mCount[1] != 0 && guard < 20) begin
      applyStimulus(6, 1'b0, 32'h0);
      guard++;
    end
    checkOutput("reload_wait", 32'(guard < 20), 32'h1);
    applyStimulus(STATUS_ADDR, 1'b1, 32'h2);
    #1;
    checkOutput("w1c_collision", 32'(ChIrq[1]), 32'h1);
    idle(3, STATUS_ADDR);

    // Ch0 square-wave, PRESET=2, then freeze by clearing EN.
    applyStimulus(1, 1'b1, 32'd2);
    applyStimulus(0, 1'b1, 32'h5);
    idle(14, 2);
    applyStimulus(0, 1'b1, 32'h4);
    idle(5, 2);

    // Masking, then immediate IRQ on setting IM.
    applyStimulus(4, 1'b1, 32'h0);
    applyStimulus(STATUS_ADDR, 1'b1, 32'h2);
    #1;
    checkOutput("masked_irq", 32'(InterruptRequest), 32'h0);
    applyStimulus(0, 1'b1, 32'hC);
    #1;
    checkOutput("im_irq", 32'(InterruptRequest), 32'h1);

    // Width truncation and unmapped addresses.
    applyStimulus(1, 1'b1, 32'h1FF);
    #1;
    checkOutput("preset_trunc", DataOut, 32'hFF);
    for (int a = 9; a < 16; a++) applyStimulus(a, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(3, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(6, 1'b1, 32'h55);
    for (int a = 0; a < 16; a++) applyStimulus(a, 1'b0, 32'h0);

    // Reset mid-count.
    applyStimulus(5, 1'b1, 32'd4);
    applyStimulus(4, 1'b1, 32'hB);
    idle(2, 6);
    @(negedge clk);
    PrAddr = ADDR_W'(6);
    WE     = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_count", DataOut, 32'h0);
    checkOutput("midreset_irq", 32'(InterruptRequest), 32'h0);
    checkOutput("midreset_wave", 32'(WaveOut), 32'h0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    idle(4, 6);

    // Random bus traffic.
    for (int i = 0; i < 400; i++) begin
      addr = $urandom_range(0, 15);
      we   = 1'($urandom_range(0, 1));
      if (addr % 4 == 1 && addr < STATUS_ADDR)
        data = 32'($urandom_range(0, 6)) | ($urandom_range(0, 3) == 0 ? 32'h100 : 32'h0);
      else
        data = $urandom;
      applyStimulus(addr, we, data);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
